// File: rtl/fma_result_drain.sv
// fma_result_drain: aligns issued FMA operands with the delayed lane-0 result,
// queues {a,b,c,result,flags} records and streams each record as four beats.
module fma_result_drain #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [WIDTH-1:0]       in_c,
  input  logic [WIDTH-1:0]       fma_out,
  input  logic [4:0]             fma_flags,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [4:0]             m_flags,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic             vld_p [LATENCY];
  logic [WIDTH-1:0] a_p   [LATENCY];
  logic [WIDTH-1:0] b_p   [LATENCY];
  logic [WIDTH-1:0] c_p   [LATENCY];

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_c [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [4:0]       mem_f [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    beat;
  logic          push;
  logic          full;
  logic          pop;
  logic          accept;

  // Tag pipe stage boundary: stage i holds the operands sampled i+1 edges ago
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    a_p[0] <= in_a;
    b_p[0] <= in_b;
    c_p[0] <= in_c;
    for (int i = 1; i < LATENCY; i++) begin
      a_p[i] <= a_p[i-1];
      b_p[i] <= b_p[i-1];
      c_p[i] <= c_p[i-1];
    end
  end

  assign push    = vld_p[LATENCY-1];
  assign full    = (level == FULL_LVL);
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready && (beat == 2'd3);
  // A full FIFO still takes the new record when the head leaves on the same edge
  assign accept  = push && (!full || pop);

  // FIFO write stage: the result meets the operands that produced it
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[wr_ptr] <= a_p[LATENCY-1];
      mem_b[wr_ptr] <= b_p[LATENCY-1];
      mem_c[wr_ptr] <= c_p[LATENCY-1];
      mem_r[wr_ptr] <= fma_out;
      mem_f[wr_ptr] <= fma_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      beat   <= 2'd0;
      drop   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (m_valid && m_ready) beat <= beat + 2'd1;
      if (push && !accept) drop <= 1'b1;
      if (accept && !pop)      level <= level + LW'(1);
      else if (pop && !accept) level <= level - LW'(1);
    end
  end

  // Output stage: head record serialized by beat, zeroed when idle
  always_comb begin
    m_data  = '0;
    m_last  = 1'b0;
    m_flags = 5'd0;
    if (m_valid) begin
      m_flags = mem_f[rd_ptr];
      m_last  = (beat == 2'd3);
      case (beat)
        2'd0:    m_data = mem_a[rd_ptr];
        2'd1:    m_data = mem_b[rd_ptr];
        2'd2:    m_data = mem_c[rd_ptr];
        default: m_data = mem_r[rd_ptr];
      endcase
    end
  end

endmodule

// File: tb/tb_fma_result_drain.sv
// Testbench for fma_result_drain: directed scenarios plus randomized traffic
// checked against a queue-based record model.
module tb_fma_result_drain;
  localparam int W = 64, LAT = 3, DEPTH = 4;

  logic clk = 1'b0;
  logic rst, issue_valid, m_ready, m_valid, m_last, drop;
  logic [W-1:0] in_a, in_b, in_c, fma_out, m_data;
  logic [4:0] fma_flags, m_flags;
  logic [2:0] level;

  always #5 clk = ~clk;

  fma_result_drain #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .fma_out(fma_out), .fma_flags(fma_flags),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_flags(m_flags), .drop(drop), .level(level)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] r;
    logic [4:0]  f;
  } rec_t;

  rec_t pend_q[$];
  int   pend_due[$];
  rec_t fifo_q[$];
  int   beat_m, cyc;
  bit   drop_m;
  rec_t cur_rec;
  int   n_checks, n_fail;

  logic        exp_valid, exp_last;
  logic [63:0] exp_data;
  logic [4:0]  exp_flags;
  int          exp_level;

  function automatic logic [63:0] field(rec_t r, int k);
    case (k)
      0: return r.a;
      1: return r.b;
      2: return r.c;
      default: return r.r;
    endcase
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.a = {$urandom, $urandom};
    r.b = {$urandom, $urandom};
    r.c = {$urandom, $urandom};
    r.r = {$urandom, $urandom};
    r.f = 5'($urandom);
    return r;
  endfunction

  // One clock: present the bench-side FMA result, advance the model, sample #1 after the edge.
  task automatic step();
    rec_t rr;
    bit   due;
    due = (pend_q.size() > 0) && (pend_due[0] == cyc + 1);
    if (due) begin
      fma_out = pend_q[0].r;
      fma_flags = pend_q[0].f;
    end else begin
      fma_out = {$urandom, $urandom};
      fma_flags = 5'($urandom);
    end
    if (issue_valid) begin
      in_a = cur_rec.a; in_b = cur_rec.b; in_c = cur_rec.c;
    end else begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_c = {$urandom, $urandom};
    end
    if (rst) begin
      pend_q.delete(); pend_due.delete(); fifo_q.delete();
      beat_m = 0; drop_m = 1'b0;
    end else begin
      bit has, adv, popm;
      has  = fifo_q.size() > 0;
      adv  = has && m_ready;
      popm = adv && beat_m == 3;
      if (adv) beat_m = (beat_m + 1) % 4;
      if (popm) void'(fifo_q.pop_front());
      if (due) begin
        rr = pend_q.pop_front();
        void'(pend_due.pop_front());
        if (fifo_q.size() < DEPTH) fifo_q.push_back(rr);
        else drop_m = 1'b1;
      end
      if (issue_valid) begin
        pend_q.push_back(cur_rec);
        pend_due.push_back(cyc + 1 + LAT);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_level = fifo_q.size();
    exp_valid = fifo_q.size() != 0;
    exp_data = '0; exp_last = 1'b0; exp_flags = '0;
    if (exp_valid) begin
      exp_data = field(fifo_q[0], beat_m);
      exp_last = (beat_m == 3);
      exp_flags = fifo_q[0].f;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid = 1'b1;
    cur_rec = rand_rec();
    m_ready = 1'($urandom);
    step();
    rst = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (m_valid !== 1'b0 || level !== 3'd0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: m_valid=%b level=%0d drop=%b want 0 0 0", m_valid, level, drop);
    end
    n_checks++;
    if (m_data !== 64'd0 || m_last !== 1'b0 || m_flags !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h last=%b flags=%b want zeros", m_data, m_last, m_flags);
    end
    m_ready = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_issue_ignored: cycle %0d m_valid=%b want 0", k, m_valid);
      end
    end
  endtask

  task automatic test_single_record();
    logic [63:0] want [4];
    do_reset();
    want[0] = 64'h3FF0000000000000; want[1] = 64'h4000000000000000;
    want[2] = 64'h4008000000000000; want[3] = 64'h4014000000000000;
    cur_rec = '{a: want[0], b: want[1], c: want[2], r: want[3], f: 5'd0};
    m_ready = 1'b1;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (m_valid !== (k >= LAT && k <= LAT + 3)) begin
        n_fail++;
        $display("FAIL single_valid: k=%0d m_valid=%b", k, m_valid);
      end
      if (k >= LAT && k <= LAT + 3) begin
        n_checks++;
        if (m_data !== want[k-LAT] || m_last !== (k == LAT + 3)) begin
          n_fail++;
          $display("FAIL single_beat: k=%0d data=%h last=%b want %h %b", k, m_data, m_last, want[k-LAT], k == LAT + 3);
        end
      end
    end
    n_checks++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_level: level=%0d want 0", level);
    end
  endtask

  task automatic test_backpressure();
    rec_t r;
    int k;
    do_reset();
    r = rand_rec();
    r.b = 64'h4000000000000000;
    cur_rec = r;
    m_ready = 1'b1;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    k = 0;
    while (!(exp_valid && beat_m == 1) && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= 20 || m_data !== r.b) begin
      n_fail++;
      $display("FAIL bp_reach_beat1: data=%h want %h after %0d cycles", m_data, r.b, k);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 64'h4000000000000000 || m_last !== 1'b0 || m_flags !== r.f) begin
        n_fail++;
        $display("FAIL bp_hold: i=%0d valid=%b data=%h last=%b flags=%b", i, m_valid, m_data, m_last, m_flags);
      end
    end
    m_ready = 1'b1;
    step();
    n_checks++;
    if (m_data !== r.c) begin
      n_fail++;
      $display("FAIL bp_resume_c: data=%h want %h", m_data, r.c);
    end
    step();
    n_checks++;
    if (m_data !== r.r || m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume_r: data=%h last=%b want %h 1", m_data, m_last, r.r);
    end
  endtask

  task automatic test_overflow();
    rec_t recs [8];
    logic [63:0] got[$];
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      recs[i] = rand_rec();
      cur_rec = recs[i];
      issue_valid = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    repeat (LAT + 1) step();
    n_checks++;
    if (level !== 3'd4 || drop !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state: level=%0d drop=%b want 4 1", level, drop);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (m_valid) got.push_back(m_data);
      step();
    end
    n_checks++;
    if (got.size() != 16) begin
      n_fail++;
      $display("FAIL ovf_beats: got %0d beats want 16", got.size());
    end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== field(recs[i/4], i%4)) begin
        n_fail++;
        $display("FAIL ovf_order: beat %0d got %h want %h", i, got[i], field(recs[i/4], i%4));
      end
    end
    n_checks++;
    if (level !== 3'd0 || drop !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end: level=%0d drop=%b want 0 1", level, drop);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur_rec = rand_rec();
      issue_valid = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    repeat (LAT) step();
    n_checks++;
    if (level !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_fill: level=%0d want 4", level);
    end
    // Head beats accepted on the next four edges; the new record arrives on the fourth.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_valid = (i == 3 - LAT);
      cur_rec = rand_rec();
      step();
      issue_valid = 1'b0;
    end
    m_ready = 1'b0;
    n_checks++;
    if (level !== 3'd4 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_same_edge: level=%0d drop=%b want 4 0", level, drop);
    end
    step();
    n_checks++;
    if (level !== 3'd4 || drop !== 1'b0 || m_data !== exp_data) begin
      n_fail++;
      $display("FAIL fullpop_after: level=%0d drop=%b data=%h want 4 0 %h", level, drop, m_data, exp_data);
    end
  endtask

  task automatic test_flags();
    int nb;
    do_reset();
    cur_rec = rand_rec();
    cur_rec.r = 64'h7FF8000000000000;
    cur_rec.f = 5'b00001;
    m_ready = 1'b1;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (m_flags !== (m_valid ? 5'b00001 : 5'b00000)) begin
        n_fail++;
        $display("FAIL flags_beat: k=%0d valid=%b flags=%b", k, m_valid, m_flags);
      end
      if (m_valid) nb++;
      if (m_last === 1'b1) begin
        n_checks++;
        if (m_data !== 64'h7FF8000000000000) begin
          n_fail++;
          $display("FAIL flags_result: data=%h want 7ff8000000000000", m_data);
        end
      end
    end
    n_checks++;
    if (nb != 4) begin
      n_fail++;
      $display("FAIL flags_count: %0d beats want 4", nb);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cur_rec = rand_rec();
      issue_valid = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    repeat (LAT) step();
    m_ready = 1'b1;
    k = 0;
    while (!(exp_valid && beat_m == 2) && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= 20 || drop !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup: drop=%b want 1 after %0d cycles", drop, k);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || level !== 3'd0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_state: valid=%b level=%0d drop=%b want 0 0 0", m_valid, level, drop);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 64'd0) begin
        n_fail++;
        $display("FAIL rmid_no_beats: i=%0d valid=%b data=%h", i, m_valid, m_data);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 79) == 0);
      issue_valid = ($urandom_range(0, 2) == 0) || (k >= 200 && k < 215);
      m_ready = ($urandom_range(0, 3) != 0);
      cur_rec = rand_rec();
      step();
      n_checks++;
      if (m_valid !== exp_valid || level !== 3'(exp_level) || drop !== drop_m) begin
        n_fail++;
        $display("FAIL rand_ctrl: k=%0d valid=%b level=%0d drop=%b want %b %0d %b", k, m_valid, level, drop, exp_valid, exp_level, drop_m);
      end
      n_checks++;
      if (m_data !== exp_data || m_last !== exp_last || m_flags !== exp_flags) begin
        n_fail++;
        $display("FAIL rand_data: k=%0d data=%h last=%b flags=%b want %h %b %b", k, m_data, m_last, m_flags, exp_data, exp_last, exp_flags);
      end
    end
    rst = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; beat_m = 0; drop_m = 1'b0;
    rst = 1'b1; issue_valid = 1'b0; m_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; fma_out = '0; fma_flags = '0;
    cur_rec = '0;
    test_reset();
    test_single_record();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_flags();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
